// File: rtl/uart_rx_if.sv
// Bundle of UART receiver line, read handshake and status signals.
// The receiver uses the slave modport; its consumer uses the master modport.
interface uart_rx_if;
   logic       serial_in;
   logic       rd_en;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_full;
   logic       parity_err;
   logic       frame_err;
   logic       overrun_err;
   logic       busy;

   modport slave (
      input  serial_in, rd_en,
      output rx_data, rx_valid, rx_full, parity_err, frame_err, overrun_err, busy
   );

   modport master (
      output serial_in, rd_en,
      input  rx_data, rx_valid, rx_full, parity_err, frame_err, overrun_err, busy
   );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB first, even parity, one stop bit, one-entry
// holding register with read handshake and parity/framing/overrun status.
module uart_rx #(
   parameter int unsigned CLKS_PER_BIT = 1
) (
   input logic       clk,
   input logic       rst,
   uart_rx_if.slave  rx_if
);
   localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned HALF  = (CLKS_PER_BIT - 1) / 2;
   localparam int unsigned IDX_W = 4;
   localparam logic [CNT_W-1:0] CNT_BIT   = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_START = CNT_W'((HALF > 0) ? HALF - 1 : 32'd0);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

   state_e             state_q, state_d;
   logic               sync1_q, sync1_d;
   logic               rx_s_q, rx_s_d;
   logic               rx_s_dly_q, rx_s_dly_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [7:0]         shift_q, shift_d;
   logic               perr_q, perr_d;
   logic [7:0]         data_q, data_d;
   logic               valid_q, valid_d;
   logic               full_q, full_d;
   logic               par_q, par_d;
   logic               ferr_q, ferr_d;
   logic               ovr_q, ovr_d;
   logic               busy_q, busy_d;
   logic               sample_c;

   // Next-state and output computation; a sample is taken when the phase counter hits zero.
   always_comb begin
      state_d    = state_q;
      sync1_d    = rx_if.serial_in;
      rx_s_d     = sync1_q;
      rx_s_dly_d = rx_s_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      shift_d    = shift_q;
      perr_d     = perr_q;
      data_d     = data_q;
      valid_d    = 1'b0;
      full_d     = full_q;
      par_d      = par_q;
      ferr_d     = 1'b0;
      ovr_d      = ovr_q;
      sample_c   = (cnt_q == '0);

      if (rx_if.rd_en) full_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (rx_s_dly_q && !rx_s_q) begin
               // With one clock per bit the start bit is sampled on the edge cycle itself.
               if (HALF == 0) begin
                  state_d = DATA;
                  cnt_d   = CNT_BIT;
                  idx_d   = '0;
               end else begin
                  state_d = START;
                  cnt_d   = CNT_START;
               end
            end
         end
         START: begin
            if (sample_c) begin
               if (rx_s_q) begin
                  state_d = IDLE;
               end else begin
                  state_d = DATA;
                  cnt_d   = CNT_BIT;
                  idx_d   = '0;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         DATA: begin
            if (sample_c) begin
               shift_d = {rx_s_q, shift_q[7:1]};
               cnt_d   = CNT_BIT;
               if (idx_q == IDX_W'(7)) state_d = PARITY;
               else                    idx_d   = idx_q + IDX_W'(1);
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         PARITY: begin
            if (sample_c) begin
               perr_d  = rx_s_q ^ (^shift_q);
               cnt_d   = CNT_BIT;
               state_d = STOP;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         STOP: begin
            if (sample_c) begin
               state_d = IDLE;
               if (rx_s_q) begin
                  data_d  = shift_q;
                  par_d   = perr_q;
                  valid_d = 1'b1;
                  full_d  = 1'b1;
                  if (full_q && !rx_if.rd_en) ovr_d = 1'b1;
               end else begin
                  ferr_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   // State and output registers; synchronizer resets to the idle line level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         sync1_q    <= 1'b1;
         rx_s_q     <= 1'b1;
         rx_s_dly_q <= 1'b1;
         cnt_q      <= '0;
         idx_q      <= '0;
         shift_q    <= '0;
         perr_q     <= 1'b0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         full_q     <= 1'b0;
         par_q      <= 1'b0;
         ferr_q     <= 1'b0;
         ovr_q      <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         sync1_q    <= sync1_d;
         rx_s_q     <= rx_s_d;
         rx_s_dly_q <= rx_s_dly_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         shift_q    <= shift_d;
         perr_q     <= perr_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         full_q     <= full_d;
         par_q      <= par_d;
         ferr_q     <= ferr_d;
         ovr_q      <= ovr_d;
         busy_q     <= busy_d;
      end
   end

   assign rx_if.rx_data     = data_q;
   assign rx_if.rx_valid    = valid_q;
   assign rx_if.rx_full     = full_q;
   assign rx_if.parity_err  = par_q;
   assign rx_if.frame_err   = ferr_q;
   assign rx_if.overrun_err = ovr_q;
   assign rx_if.busy        = busy_q;
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at one and sixteen clocks per bit: directed frames plus a
// randomized frame stream checked against a frame-level reference model.
module tb_uart_rx;
   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_rx_if if1 ();
   uart_rx_if if16 ();

   uart_rx #(.CLKS_PER_BIT(1))  u_dut1  (.clk(clk), .rst(rst), .rx_if(if1));
   uart_rx #(.CLKS_PER_BIT(16)) u_dut16 (.clk(clk), .rst(rst), .rx_if(if16));

   typedef struct {
      int         cyc;
      logic [7:0] data;
      logic       perr;
      logic       ferr;
      logic       valid;
   } ev_t;

   ev_t evq1[$];
   ev_t evq16[$];
   ev_t expq[$];

   // Log every data-valid or framing-error pulse with the cycle it was seen.
   always @(negedge clk) begin
      if (if1.rx_valid === 1'b1 || if1.frame_err === 1'b1)
         evq1.push_back('{cyc, if1.rx_data, if1.parity_err, if1.frame_err, if1.rx_valid});
      if (if16.rx_valid === 1'b1 || if16.frame_err === 1'b1)
         evq16.push_back('{cyc, if16.rx_data, if16.parity_err, if16.frame_err, if16.rx_valid});
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [10:0] make_frame(input logic [7:0] d, input logic par, input logic stp);
      return {stp, par, d, 1'b0};
   endfunction

   // Cycles from driving the start bit until the result pulse is visible:
   // two synchronizer stages, then 10 bit periods plus half a bit plus one register.
   function automatic int lat(input bit big);
      int cpb;
      cpb = big ? 16 : 1;
      return 2 + 10 * cpb + (cpb - 1) / 2 + 1;
   endfunction

   task automatic drive(input bit big, input logic b);
      if (big) if16.serial_in = b;
      else     if1.serial_in  = b;
   endtask

   task automatic send(input bit big, input logic [10:0] f, input int max_cyc, output int k);
      int cpb;
      int n;
      cpb = big ? 16 : 1;
      n   = 0;
      k   = cyc;
      for (int b = 0; b < 11; b++) begin
         for (int c = 0; c < cpb; c++) begin
            if (n == max_cyc) return;
            drive(big, f[b]);
            tick();
            n++;
         end
      end
   endtask

   task automatic expect_ev(input bit big, input string tag, input int k,
                            input logic [7:0] d, input logic perr, input logic ferr);
      ev_t e;
      int  sz;
      sz = big ? evq16.size() : evq1.size();
      check({tag, "_present"}, 32'(sz > 0), 32'd1);
      if (sz == 0) return;
      e = big ? evq16.pop_front() : evq1.pop_front();
      check({tag, "_cycle"}, e.cyc, k + lat(big));
      check({tag, "_ferr"},  32'(e.ferr),  32'(ferr));
      check({tag, "_valid"}, 32'(e.valid), 32'(!ferr));
      check({tag, "_data"},  32'(e.data),  32'(d));
      check({tag, "_perr"},  32'(e.perr),  32'(perr));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive(0, 1'b1);
      drive(1, 1'b1);
      if1.rd_en  = 1'b0;
      if16.rd_en = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      tick();
   endtask

   initial begin
      int         k, k2, gap;
      logic [7:0] d;
      logic       pbad, sbad, do_rd;
      logic       m_full, m_ovr, m_perr;
      logic [7:0] m_data;

      rst = 1'b1;
      if1.serial_in  = 1'b1;
      if16.serial_in = 1'b1;
      if1.rd_en      = 1'b0;
      if16.rd_en     = 1'b0;
      do_reset();

      // Idle line after reset.
      repeat (20) tick();
      check("rst_data",    32'(if1.rx_data),     32'd0);
      check("rst_valid",   32'(if1.rx_valid),    32'd0);
      check("rst_full",    32'(if1.rx_full),     32'd0);
      check("rst_perr",    32'(if1.parity_err),  32'd0);
      check("rst_ferr",    32'(if1.frame_err),   32'd0);
      check("rst_ovr",     32'(if1.overrun_err), 32'd0);
      check("rst_busy",    32'(if1.busy),        32'd0);
      check("rst_busy16",  32'(if16.busy),       32'd0);
      check("rst_data16",  32'(if16.rx_data),    32'd0);
      check("rst_noev",    32'(evq1.size() + evq16.size()), 32'd0);

      // Single byte at one clock per bit.
      send(0, make_frame(8'hA5, ^8'hA5, 1'b1), 1000, k);
      repeat (4) tick();
      expect_ev(0, "a5", k, 8'hA5, 1'b0, 1'b0);
      check("a5_full",  32'(if1.rx_full), 32'd1);
      check("a5_single", 32'(evq1.size()), 32'd0);
      if1.rd_en = 1'b1; tick(); if1.rd_en = 1'b0; tick();
      check("a5_read_clears", 32'(if1.rx_full), 32'd0);
      if1.rd_en = 1'b1; tick(); if1.rd_en = 1'b0; tick();
      check("rd_empty", 32'(if1.rx_full), 32'd0);

      // Sixteen clocks per bit: bad parity, then bad stop bit.
      send(1, make_frame(8'h01, 1'b0, 1'b1), 1000, k);
      tick();
      expect_ev(1, "perr01", k, 8'h01, 1'b1, 1'b0);
      send(1, make_frame(8'h3C, ^8'h3C, 1'b0), 1000, k);
      drive(1, 1'b1);
      repeat (2) tick();
      expect_ev(1, "ferr3c", k, 8'h01, 1'b1, 1'b1);
      check("ferr3c_full", 32'(if16.rx_full), 32'd1);

      // Five-cycle low glitch is rejected at the start-bit sample.
      k = cyc;
      drive(1, 1'b0);
      tick(); tick();
      check("glitch_busy_pre", 32'(if16.busy), 32'd0);
      tick();
      check("glitch_busy_on", 32'(if16.busy), 32'd1);
      tick(); tick();
      drive(1, 1'b1);
      while (cyc < k + 15) tick();
      check("glitch_busy_off", 32'(if16.busy), 32'd0);
      repeat (200) tick();
      check("glitch_noev", 32'(evq16.size()), 32'd0);

      // Reset during data bit 4 abandons the frame, then a clean frame follows.
      send(1, make_frame(8'hC3, ^8'hC3, 1'b1), 85, k);
      check("midrst_busy_pre", 32'(if16.busy), 32'd1);
      rst = 1'b1;
      #1;
      check("midrst_data", 32'(if16.rx_data),    32'd0);
      check("midrst_full", 32'(if16.rx_full),    32'd0);
      check("midrst_perr", 32'(if16.parity_err), 32'd0);
      check("midrst_busy", 32'(if16.busy),       32'd0);
      drive(1, 1'b1);
      tick(); tick();
      rst = 1'b0;
      repeat (3) tick();
      repeat (200) tick();
      check("midrst_noev", 32'(evq16.size()), 32'd0);
      send(1, make_frame(8'h5A, ^8'h5A, 1'b1), 1000, k);
      tick();
      expect_ev(1, "post_rst_5a", k, 8'h5A, 1'b0, 1'b0);

      // Back-to-back frames without a read cause overrun.
      send(0, make_frame(8'h11, ^8'h11, 1'b1), 1000, k);
      send(0, make_frame(8'h22, ^8'h22, 1'b1), 1000, k2);
      repeat (4) tick();
      expect_ev(0, "b2b_11", k,  8'h11, 1'b0, 1'b0);
      expect_ev(0, "b2b_22", k2, 8'h22, 1'b0, 1'b0);
      check("b2b_gap", k2 - k, 32'd11);
      check("b2b_ovr", 32'(if1.overrun_err), 32'd1);

      // Read on the second write cycle: still full, no overrun.
      do_reset();
      send(0, make_frame(8'h11, ^8'h11, 1'b1), 1000, k);
      send(0, make_frame(8'h22, ^8'h22, 1'b1), 1000, k2);
      tick();
      if1.rd_en = 1'b1;
      tick();
      if1.rd_en = 1'b0;
      check("rdw_full", 32'(if1.rx_full),     32'd1);
      check("rdw_ovr",  32'(if1.overrun_err), 32'd0);
      repeat (2) tick();
      expect_ev(0, "rdw_11", k,  8'h11, 1'b0, 1'b0);
      expect_ev(0, "rdw_22", k2, 8'h22, 1'b0, 1'b0);

      // Randomized frame stream against a frame-level model.
      do_reset();
      evq1.delete();
      m_full = 1'b0; m_ovr = 1'b0; m_perr = 1'b0; m_data = 8'h00;
      for (int i = 0; i < 24; i++) begin
         d    = 8'($urandom);
         pbad = ($urandom_range(0, 3) == 0);
         sbad = ($urandom_range(0, 7) == 0);
         send(0, make_frame(d, (^d) ^ pbad, !sbad), 1000, k);
         if (sbad) begin
            expq.push_back('{k, m_data, m_perr, 1'b1, 1'b0});
         end else begin
            if (m_full) m_ovr = 1'b1;
            m_full = 1'b1;
            m_data = d;
            m_perr = pbad;
            expq.push_back('{k, m_data, m_perr, 1'b0, 1'b1});
         end
         drive(0, 1'b1);
         gap = $urandom_range(0, 4);
         if (sbad && gap == 0) gap = 1;
         do_rd = (gap >= 3) && ($urandom_range(0, 1) == 1);
         for (int g = 0; g < gap; g++) begin
            if (do_rd && g == gap - 1) if1.rd_en = 1'b1;
            tick();
            if1.rd_en = 1'b0;
         end
         if (do_rd) m_full = 1'b0;
      end
      repeat (5) tick();
      while (expq.size() > 0) begin
         ev_t e;
         e = expq.pop_front();
         expect_ev(0, "rnd", e.cyc, e.data, e.perr, e.ferr);
      end
      check("rnd_extra", 32'(evq1.size()),       32'd0);
      check("rnd_full",  32'(if1.rx_full),       32'(m_full));
      check("rnd_ovr",   32'(if1.overrun_err),   32'(m_ovr));
      check("rnd_data",  32'(if1.rx_data),       32'(m_data));
      check("rnd_perr",  32'(if1.parity_err),    32'(m_perr));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial-to-parallel UART receiver.
- Sits directly downstream of the team's UART transmitter and consumes its `serial_out` line.
- Frame format: idle-high line, 1 start bit (0), 8 data bits LSB first, 1 even-parity bit (parity = XOR of the 8 data bits), 1 stop bit (1).
- Delivers each byte through a one-entry holding register with a read handshake, plus parity, framing and overrun flags.

Parameters:
- `CLKS_PER_BIT`, default 1: clock cycles per serial bit. Legal range 1..1024. Default 1 matches the transmitter's one-bit-per-clock output.

Ports:
- `clk` input 1: single clock, all logic on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `serial_in` input 1: UART line (transmitter `serial_out`).
- `rd_en` input 1: consumer acknowledge; clears `rx_full`.
- `rx_data` output 8: last accepted byte.
- `rx_valid` output 1: one-cycle pulse when a byte is written to `rx_data`.
- `rx_full` output 1: holding register contains an unread byte.
- `parity_err` output 1: parity result of the byte in `rx_data`.
- `frame_err` output 1: one-cycle pulse when the stop bit samples 0.
- `overrun_err` output 1: sticky; a byte was written while `rx_full` was 1.
- `busy` output 1: FSM is not in IDLE.

Behaviour:
- Reset: async, active-high.
  - `rx_data`=0x00; `rx_valid`, `rx_full`, `parity_err`, `frame_err`, `overrun_err`, `busy` all 0.
  - FSM to IDLE.
  - Synchronizer flops and the edge-detect flop reset to 1 (line idle).
  - Reset mid-frame abandons the frame; no flag or pulse is produced.
- Synchronizer: `serial_in` passes through two flops to form `rx_s`. `rx_s_d` is `rx_s` delayed one cycle, updated every cycle in every state.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Start detection (IDLE):
  - Falling edge `rx_s_d`=1 and `rx_s`=0 at cycle t0 leaves IDLE.
  - A line held low does not retrigger.
- Sample schedule:
  - Bit n (0=start, 1..8=data, 9=parity, 10=stop) is sampled from `rx_s` at cycle t0 + n*CLKS_PER_BIT + (CLKS_PER_BIT-1)/2, using integer division.
  - CLKS_PER_BIT=1: cycles t0..t0+10. CLKS_PER_BIT=16: t0+7, t0+23, …
  - Counter widths: $clog2(CLKS_PER_BIT) bits for the bit-phase counter (minimum 1), 4 bits for the bit index.
- START:
  - Start sample = 1: false start; return to IDLE, no outputs change.
  - Start sample = 0: go to DATA.
- DATA:
  - Shift register shifts right; the sampled bit enters bit 7, so the LSB arrives first.
  - After the 8th data sample, go to PARITY.
- PARITY: capture `perr` = sampled bit XOR (XOR of shift register); go to STOP.
- STOP, stop sample = 1 (cycle ts):
  - At ts+1: `rx_data` <= shift register, `parity_err` <= `perr`, `rx_valid`=1 for exactly one cycle, `rx_full`=1.
  - If `rx_full` was already 1 and `rd_en` is not asserted that cycle, `overrun_err` <= 1; the new byte still overwrites.
- STOP, stop sample = 0:
  - At ts+1: `frame_err`=1 for one cycle.
  - `rx_data`, `rx_full` and `parity_err` are unchanged; no `rx_valid`.
- After STOP, the FSM is in IDLE at ts+1.
  - A new falling edge can be detected at ts+1, so back-to-back frames with CLKS_PER_BIT=1 are received with no gap.
- `rd_en`:
  - `rd_en`=1 clears `rx_full` next cycle.
  - `rd_en` in the same cycle as a byte write: `rx_full` stays 1, no overrun.
  - `rd_en` while empty: no effect.
- `overrun_err` is cleared only by reset.
- `busy`=1 in every state except IDLE.
- Latency: `rx_valid` at t0 + 10*CLKS_PER_BIT + (CLKS_PER_BIT-1)/2 + 1; that is t0+11 for CLKS_PER_BIT=1.

Test Plan:
- Reset, line held 1 for 20 cycles -> all outputs 0, `busy`=0, `rx_data`=0x00.
- CLKS_PER_BIT=1, drive through the transmitter with byte 0xA5 -> `rx_valid` pulse at t0+11, `rx_data`=0xA5, `parity_err`=0, `rx_full`=1.
- CLKS_PER_BIT=16, frame 0x01 with parity bit forced to 0 -> `rx_data`=0x01, `parity_err`=1. Then frame 0x3C with stop bit forced to 0 -> `frame_err` pulse, `rx_data` still 0x01, no `rx_valid`.
- CLKS_PER_BIT=16, a 5-cycle low glitch on an idle line -> start sample at t0+7 reads 1; FSM returns to IDLE, no `rx_valid`, `busy` drops to 0.
- CLKS_PER_BIT=1, back-to-back frames 0x11 then 0x22 with no `rd_en` -> two `rx_valid` pulses 11 cycles apart, `rx_data`=0x22, `overrun_err`=1. Repeat with `rd_en` asserted on the second write cycle -> `overrun_err`=0, `rx_full`=1.
- CLKS_PER_BIT=16, assert `rst` at data bit 4 of a frame -> all outputs 0 immediately. Then send 0x5A -> received correctly with `parity_err`=0.
